// File: rtl/fib_checker.sv
// Fibonacci stream checker: compares a generator's 16-bit terms against 0, 1, 1, 2, ... 46368.
// Optional macro FIB_CHK_ERR_CAPTURE_EN builds the err_data capture register; otherwise err_data is 0.
`timescale 1ns/1ps
module fib_checker #(
  parameter int W        = 16,
  parameter int CW       = 8,
  parameter int LAST_IDX = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_valid,
  input  logic [W-1:0]  f_out,
  input  logic          clr,
  output logic [W-1:0]  exp_out,
  output logic [CW-1:0] term_cnt,
  output logic          err,
  output logic [CW-1:0] err_idx,
  output logic [W-1:0]  err_data,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL, S_DONE} state_t;

  typedef struct packed {
    logic [W-1:0]  prev;
    logic [W-1:0]  cur;
    logic [CW-1:0] cnt;
  } ctx_t;

  state_t state, state_nxt;
  ctx_t   ctx;
  logic   sample, hit, last;
  logic [W:0] sum;

  assign sample = f_valid && (state == S_IDLE || state == S_RUN);
  assign hit    = (f_out == ctx.cur);
  assign last   = (ctx.cnt == CW'(LAST_IDX));
  assign sum    = {1'b0, ctx.prev} + {1'b0, ctx.cur};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)
      state_nxt = S_IDLE;
    else if (sample) begin
      if (!hit)                        state_nxt = S_FAIL;
      else if (state == S_RUN && last) state_nxt = S_DONE;
      else                             state_nxt = S_RUN;
    end
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    err  = (state == S_FAIL);
  end

  // prev starts at 1 (the term before 0), so the first match yields cur = 0 + 1 with the same adder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctx     <= '{prev: W'(1), cur: '0, cnt: '0};
      err_idx <= '0;
    end else if (clr) begin
      ctx     <= '{prev: W'(1), cur: '0, cnt: '0};
      err_idx <= '0;
    end else if (sample) begin
      if (hit) begin
        ctx.cnt <= (ctx.cnt == '1) ? ctx.cnt : ctx.cnt + 1'b1;
        // The last term freezes the pair so the overflowing sum is never exposed.
        if (!(state == S_RUN && last)) begin
          ctx.prev <= ctx.cur;
          ctx.cur  <= sum[W-1:0];
        end
      end else begin
        err_idx <= ctx.cnt;
      end
    end
  end

`ifdef FIB_CHK_ERR_CAPTURE_EN
  logic [W-1:0] err_data_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  err_data_q <= '0;
    else if (clr)              err_data_q <= '0;
    else if (sample && !hit)   err_data_q <= f_out;
  end
  assign err_data = err_data_q;
`else
  assign err_data = '0;
`endif

  assign exp_out  = ctx.cur;
  assign term_cnt = ctx.cnt;

  // A carry out of the adder may only occur once the final term has been accepted.
  a_no_ovf: assert property (@(posedge clk) disable iff (!rst)
    (sample && hit && state == S_RUN && !last) |-> !sum[W]);

endmodule

// File: tb/tb_fib_checker.sv
// Self-checking bench for fib_checker: vector table plus per-cycle scoreboard against a reference model.
`timescale 1ns/1ps
module tb_fib_checker;
  logic        clk = 1'b0, rst = 1'b0, f_valid = 1'b0, clr = 1'b0;
  logic [15:0] f_out = '0;
  logic [15:0] exp_out, err_data;
  logic [7:0]  term_cnt, err_idx;
  logic        err, done, busy;

  fib_checker dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_out(f_out), .clr(clr),
    .exp_out(exp_out), .term_cnt(term_cnt), .err(err), .err_idx(err_idx),
    .err_data(err_data), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] exp_out;
    logic [7:0]  term_cnt;
    logic        err;
    logic [7:0]  err_idx;
    logic [15:0] err_data;
    logic        done;
    logic        busy;
  } out_t;

  typedef struct {
    logic        v;
    logic        c;
    logic [15:0] d;
    logic [7:0]  cnt;
    logic        err;
  } vec_t;

  int          n_chk = 0, n_fail = 0;
  logic [15:0] fib [25];
  out_t        sbq[$];
  vec_t        tbl[$];

  // Reference model: 0 idle, 1 run, 2 fail, 3 done
  int          m_st, m_cnt;
  logic [7:0]  m_eidx;
  logic [15:0] m_edata;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_eidx = '0; m_edata = '0;
  endtask

  task automatic model_step(input logic v, input logic c, input logic [15:0] d);
    if (c) model_reset();
    else if (v && (m_st == 0 || m_st == 1)) begin
      if (d == fib[m_cnt]) begin
        m_cnt++;
        m_st = (m_cnt == 25) ? 3 : 1;
      end else begin
        m_st = 2; m_eidx = 8'(m_cnt); m_edata = d;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    o.exp_out  = fib[(m_cnt > 24) ? 24 : m_cnt];
    o.term_cnt = 8'(m_cnt);
    o.err      = (m_st == 2);
    o.err_idx  = m_eidx;
`ifdef FIB_CHK_ERR_CAPTURE_EN
    o.err_data = m_edata;
`else
    o.err_data = '0;
`endif
    o.done     = (m_st == 3);
    o.busy     = (m_st == 1);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input out_t e);
    chk("exp_out",  32'(exp_out),  32'(e.exp_out));
    chk("term_cnt", 32'(term_cnt), 32'(e.term_cnt));
    chk("err",      32'(err),      32'(e.err));
    chk("err_idx",  32'(err_idx),  32'(e.err_idx));
    chk("err_data", 32'(err_data), 32'(e.err_data));
    chk("done",     32'(done),     32'(e.done));
    chk("busy",     32'(busy),     32'(e.busy));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_exp_out"},  32'(exp_out),  0);
    chk({tag, "_term_cnt"}, 32'(term_cnt), 0);
    chk({tag, "_err"},      32'(err),      0);
    chk({tag, "_err_idx"},  32'(err_idx),  0);
    chk({tag, "_err_data"}, 32'(err_data), 0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_busy"},     32'(busy),     0);
  endtask

  task automatic cycle(input logic v, input logic c, input logic [15:0] d);
    @(negedge clk);
    f_valid = v; clr = c; f_out = d;
    model_step(v, c, d);
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) chk("scoreboard_empty", 1, 0);
    else check_out(sbq.pop_front());
  endtask

  task automatic stream(input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      cycle(1'b1, 1'b0, fib[i]);
      if (gaps) cycle(1'b0, 1'b0, 16'h1234);
    end
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_cnt"},  32'(term_cnt), 25);
    chk({tag, "_done"}, 32'(done),     1);
    chk({tag, "_err"},  32'(err),      0);
    chk({tag, "_busy"}, 32'(busy),     0);
    chk({tag, "_exp"},  32'(exp_out),  46368);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    fib[0] = 16'd0; fib[1] = 16'd1;
    for (int i = 2; i < 25; i++) fib[i] = fib[i-1] + fib[i-2];
    model_reset();

    // Reset state
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Short sequences: {valid, clr, f_out, term_cnt, err}
    tbl.push_back('{1'b1, 1'b0, 16'd0, 8'd1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd1, 8'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 16'd5, 8'd2, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd1, 8'd3, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd1, 8'd3, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 16'd2, 8'd3, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 16'd1, 8'd3, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 16'd0, 8'd0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 16'd1, 8'd0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 16'd0, 8'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 16'd0, 8'd0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].d);
      chk("tbl_cnt", 32'(term_cnt), 32'(tbl[i].cnt));
      chk("tbl_err", 32'(err),      32'(tbl[i].err));
    end

    // Full stream with f_valid held high, then held in DONE
    stream(0, 24, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'hFFFF);
    check_done("full");
    cycle(1'b0, 1'b1, 16'd0);

    // Same stream with f_valid gaps
    stream(0, 24, 1'b1);
    check_done("gaps");
    cycle(1'b0, 1'b1, 16'd0);

    // clr and f_valid together at term_cnt=5
    stream(0, 4, 1'b0);
    chk("clr_pre_cnt", 32'(term_cnt), 5);
    cycle(1'b1, 1'b1, fib[5]);
    chk("clr_cnt", 32'(term_cnt), 0);
    cycle(1'b1, 1'b0, 16'd0);
    chk("clr_next_cnt", 32'(term_cnt), 1);
    cycle(1'b0, 1'b1, 16'd0);

    // Asynchronous reset mid-cycle at term_cnt=10
    stream(0, 9, 1'b0);
    chk("arst_pre_cnt", 32'(term_cnt), 10);
    f_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    stream(0, 24, 1'b0);
    check_done("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fib_checker.md
FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port f_valid, input, 1 bit: the Fibonacci generator's valid/enable strobe; f_out is sampled only when it is high.
REQ-004 SHALL have port f_out, input, 16 bits: the generator's current term.
REQ-005 SHALL have port clr, input, 1 bit: synchronous restart of checking.
REQ-006 SHALL have port exp_out, output, 16 bits: the term expected at the next sample.
REQ-007 SHALL have port term_cnt, output, 8 bits: count of terms accepted and matched.
REQ-008 SHALL have port err, output, 1 bit: sticky mismatch flag.
REQ-009 SHALL have port err_idx, output, 8 bits: term_cnt value at the first mismatch.
REQ-010 SHALL have port err_data, output, 16 bits: the f_out value captured at the first mismatch (see Configuration).
REQ-011 SHALL have port done, output, 1 bit: high once the last 16-bit term has been checked.
REQ-012 SHALL have port busy, output, 1 bit: high in state RUN.

Function
REQ-013 SHALL check against the expected sequence 0, 1, 1, 2, 3, 5, 8, ..., 46368 (indices 0..24); the first sample after reset or clr is expected to be 0.
REQ-014 SHALL keep the state machine IDLE, RUN, FAIL, DONE; after reset the state is IDLE.
REQ-015 IDLE: on f_valid=1, SHALL compare f_out with 0; on a match, go to RUN with term_cnt=1; on a mismatch, go to FAIL.
REQ-016 RUN: on each f_valid=1 edge, SHALL compare f_out with exp_out.
- Match: term_cnt increments and the expected pair advances (next = a+b, computed in 17 bits).
- Mismatch: go to FAIL.
- f_valid=0: hold all state.
REQ-017 SHALL go to DONE, with done=1, when index 24 (46368) matches; the 17-bit sum 75025 SHALL never be presented on exp_out.
REQ-018 FAIL: on entry, SHALL set err=1, err_idx=term_cnt, and capture err_data; FAIL and DONE SHALL ignore f_valid and hold their outputs until clr or reset.
REQ-019 SHALL update each output one cycle after the sampling edge; the comparison itself SHALL be combinational against registered exp_out.
REQ-020 SHALL apply the arithmetic rule exp_out = previous two matched terms summed; term_cnt SHALL saturate at 255 (unreachable in normal use).
REQ-021 clr=1 SHALL return the block to IDLE with all outputs at their reset values; clr and f_valid in the same cycle: clr wins and the sample is discarded.
REQ-022 A repeated term (e.g. 1, 1, 1) SHALL be a mismatch at index 3 (expected 2).

Reset
REQ-023 rst=0 SHALL immediately force:
- state=IDLE;
- exp_out=0, term_cnt=0, err=0, err_idx=0, err_data=0, done=0, busy=0.
Reset asserted mid-sequence SHALL discard all progress.
REQ-024 Reset SHALL be released synchronously to clk by the surrounding system; the block SHALL have no internal synchronizer.

Configuration
REQ-025 Macro FIB_CHK_ERR_CAPTURE_EN:
- Defined: err_data holds the f_out value seen at the first mismatch.
- Undefined: the capture register is not built and err_data is tied to 0.
- All other behaviour is identical either way.

Verification
REQ-026 Reset, then f_valid held high with a correct stream 0..46368 -> term_cnt=25, done=1, err=0, exp_out frozen, busy=0.
REQ-027 Stream 0, 1, 1, 1 -> err=1, err_idx=3, err_data=1 (macro defined) or 0 (undefined), state FAIL held while f_valid continues.
REQ-028 Stream with f_valid gaps (toggled every other cycle) with correct values -> same result as REQ-026; no term is skipped or double-counted.
REQ-029 At term_cnt=10, assert rst=0 asynchronously mid-cycle -> all outputs 0 immediately; the next stream starting at 0 checks cleanly.
REQ-030 clr and f_valid asserted together at term_cnt=5 -> IDLE with term_cnt=0; the following sample 0 is accepted and term_cnt=1.
REQ-031 First sample 1 instead of 0 -> err=1, err_idx=0, busy stays 0.
